// File: rtl/demux3_if.sv
// Producer/consumer bundle for the eight-way registered demultiplexer.
// The slave modport is the demultiplexer's view; master is the testbench/producer view.
interface demux3_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_pos;
  logic [31:0] in_data;
  logic [31:0] data1, data2, data3, data4, data5, data6, data7, data8;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;

  modport slave (
    input  in_valid, in_pos, in_data, out_ready,
    output in_ready, out_valid,
    output data1, data2, data3, data4, data5, data6, data7, data8
  );

  modport master (
    output in_valid, in_pos, in_data, out_ready,
    input  in_ready, out_valid,
    input  data1, data2, data3, data4, data5, data6, data7, data8
  );
endinterface

// File: rtl/demux3.sv
// Eight-way registered demultiplexer: one tagged 32-bit word per cycle into eight
// single-entry valid/ready slots. Define DEMUX3_STATS_EN to add the accept_cnt counter.
module demux3 (
  input  logic        clk,
  input  logic        rst_n,
  demux3_if.slave     bus
`ifdef DEMUX3_STATS_EN
  ,
  output logic [15:0] accept_cnt
`endif
);

  logic [7:0]  valid_q, valid_d;
  logic [31:0] data_q [8];
  logic [31:0] data_d [8];
  logic        in_fire;

  // Ready depends only on the addressed slot, so a stalled slot blocks nothing else.
  assign bus.in_ready = ~valid_q[bus.in_pos] | bus.out_ready[bus.in_pos];
  assign in_fire      = bus.in_valid & bus.in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    valid_d = valid_q & ~bus.out_ready;
    data_d  = data_q;
    if (in_fire) begin
      valid_d[bus.in_pos] = 1'b1;
      data_d[bus.in_pos]  = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      // NOTE: the data array is reset because consumers see data1..data8 directly.
      for (int i = 0; i < 8; i++) data_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.data1     = data_q[0];
  assign bus.data2     = data_q[1];
  assign bus.data3     = data_q[2];
  assign bus.data4     = data_q[3];
  assign bus.data5     = data_q[4];
  assign bus.data6     = data_q[5];
  assign bus.data7     = data_q[6];
  assign bus.data8     = data_q[7];

`ifdef DEMUX3_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign accept_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux3.sv
// Self-checking bench for demux3: a per-slot scoreboard queue plus directed scenario tasks.
// Build with +define+DEMUX3_STATS_EN to also exercise the accept counter.
`timescale 1ns/1ps
module tb_demux3;
  logic clk = 1'b0;
  logic rst_n;
  demux3_if bus();
`ifdef DEMUX3_STATS_EN
  logic [15:0] accept_cnt;
`endif

  demux3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef DEMUX3_STATS_EN
    ,
    .accept_cnt (accept_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] dout [8];
  assign dout[0] = bus.data1;
  assign dout[1] = bus.data2;
  assign dout[2] = bus.data3;
  assign dout[3] = bus.data4;
  assign dout[4] = bus.data5;
  assign dout[5] = bus.data6;
  assign dout[6] = bus.data7;
  assign dout[7] = bus.data8;

  // Scoreboard: pending words per slot, last word loaded per slot, expected count.
  logic [31:0] exp_q [8][$];
  logic [31:0] exp_data [8];
  logic [15:0] exp_cnt = '0;

  initial for (int i = 0; i < 8; i++) exp_data[i] = '0;

  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_rdy;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (bus.out_valid[i] !== (exp_q[i].size() != 0)) begin
          errors++;
          $display("FAIL sb_valid slot%0d got %b exp %b", i + 1, bus.out_valid[i], exp_q[i].size() != 0);
        end
        checks++;
        if (dout[i] !== exp_data[i]) begin
          errors++;
          $display("FAIL sb_data slot%0d got %h exp %h", i + 1, dout[i], exp_data[i]);
        end
      end
      exp_rdy = (exp_q[bus.in_pos].size() == 0) || bus.out_ready[bus.in_pos];
      checks++;
      if (bus.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL sb_in_ready pos%0d got %b exp %b", bus.in_pos, bus.in_ready, exp_rdy);
      end
`ifdef DEMUX3_STATS_EN
      checks++;
      if (accept_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL sb_accept_cnt got %h exp %h", accept_cnt, exp_cnt);
      end
`endif
      if (!rst_n) begin
        for (int i = 0; i < 8; i++) begin
          exp_q[i].delete();
          exp_data[i] = '0;
        end
        exp_cnt = '0;
      end else begin
        for (int i = 0; i < 8; i++)
          if (exp_q[i].size() != 0 && bus.out_ready[i]) void'(exp_q[i].pop_front());
        if (bus.in_valid && exp_rdy) begin
          exp_q[bus.in_pos].push_back(bus.in_data);
          exp_data[bus.in_pos] = bus.in_data;
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_pos    = 3'd0;
    bus.in_data   = '0;
    bus.out_ready = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b1;
    bus.in_pos    = 3'd3;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 8'h00;
    rst_n = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 8'h00) begin
      errors++;
      $display("FAIL reset_out_valid got %h exp 00", bus.out_valid);
    end
    checks++;
    if (bus.data4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_data4 got %h exp 0", bus.data4);
    end
`ifdef DEMUX3_STATS_EN
    checks++;
    if (accept_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_accept_cnt got %h exp 0", accept_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1;
    bus.in_pos   = 3'b101;
    bus.in_data  = 32'h12345678;
    tick();
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 8'b0010_0000 || bus.data6 !== 32'h12345678) begin
        errors++;
        $display("FAIL single_hold got %h/%h exp 20/12345678", bus.out_valid, bus.data6);
      end
      tick();
    end
    bus.out_ready = 8'b0010_0000;
    tick();
    bus.out_ready = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 8'h00 || bus.data6 !== 32'h12345678) begin
      errors++;
      $display("FAIL single_drain got %h/%h exp 00/12345678", bus.out_valid, bus.data6);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.in_valid = 1'b1;
    bus.in_pos   = 3'd1;
    bus.in_data  = 32'h0000_0022;
    tick();
    bus.in_data  = 32'h0000_0099;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_blocked_ready got %b exp 0", bus.in_ready);
    end
    tick();
    bus.in_pos  = 3'd2;
    bus.in_data = 32'h0000_0033;
    @(negedge clk);
    checks++;
    if (bus.data2 !== 32'h22 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_switch got data2=%h ready=%b exp 22/1", bus.data2, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 8'b0000_0110 || bus.data3 !== 32'h33) begin
      errors++;
      $display("FAIL bp_loaded got %h/%h exp 06/33", bus.out_valid, bus.data3);
    end
    bus.out_ready = 8'hFF;
    tick();
    idle();
    tick();
  endtask

  task automatic test_refill();
    bus.in_valid = 1'b1;
    bus.in_pos   = 3'd0;
    bus.in_data  = 32'hA;
    tick();
    bus.in_data   = 32'hB;
    bus.out_ready = 8'h01;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL refill_ready got %b exp 1", bus.in_ready);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (bus.out_valid[0] !== 1'b1 || bus.data1 !== 32'hB) begin
      errors++;
      $display("FAIL refill_data got %b/%h exp 1/0000000b", bus.out_valid[0], bus.data1);
    end
    bus.out_ready = 8'h01;
    tick();
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_ov;
    do_reset();
    bus.out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pos   = 3'(i);
      bus.in_data  = 32'h100 + 32'(i);
      tick();
      exp_ov = 8'h01 << i;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== exp_ov) begin
        errors++;
        $display("FAIL b2b_pulse%0d got %h exp %h", i, bus.out_valid, exp_ov);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 8'h00) begin
      errors++;
      $display("FAIL b2b_drained got %h exp 00", bus.out_valid);
    end
`ifdef DEMUX3_STATS_EN
    checks++;
    if (accept_cnt !== 16'd8) begin
      errors++;
      $display("FAIL b2b_accept_cnt got %0d exp 8", accept_cnt);
    end
`endif
    idle();
    tick();
  endtask

`ifdef DEMUX3_STATS_EN
  task automatic test_saturation();
    do_reset();
    bus.out_ready = 8'hFF;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      bus.in_pos  = 3'(i);
      bus.in_data = 32'(i);
      tick();
    end
    @(negedge clk);
    checks++;
    if (accept_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_cnt got %h exp ffff", accept_cnt);
    end
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (accept_cnt !== 16'h0) begin
      errors++;
      $display("FAIL sat_reset got %h exp 0", accept_cnt);
    end
    rst_n = 1'b1;
    idle();
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_refill();
    test_back_to_back();
`ifdef DEMUX3_STATS_EN
    test_saturation();
`endif
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/demux3.md
# demux3

Eight-way registered demultiplexer for the CPU-31 datapath, performing the inverse of the 8:1 selector. It accepts one 32-bit word per cycle tagged with a 3-bit destination index and steers it into one of eight single-entry holding slots. Each slot presents its word to its own consumer with a valid/ready handshake. It sits between a shared producer (ALU/memory result bus) and eight independent consumers (write-back targets, forwarding latches, I/O sinks).

## Interface
Parameters:
- none; data width fixed at 32, slot count fixed at 8.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk edge.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  block accepts the word this cycle.
- in_pos  input  3  destination slot index: 3'b000 selects slot 1 … 3'b111 selects slot 8.
- in_data  input  32  word to deliver.
- data1 … data8  output  32 each  slot contents.
- out_valid  output  8  bit i-1 set means slot i holds an undelivered word.
- out_ready  input  8  bit i-1 set means consumer i takes slot i this cycle.
- accept_cnt  output  16  saturating count of accepted input words; present only with DEMUX3_STATS_EN.

## Operation
- Per-slot state: 32-bit data register and 1-bit valid flag. Two states per slot: EMPTY (valid=0) and FULL (valid=1).
- Input accept: `in_ready = ~out_valid[in_pos] | out_ready[in_pos]`. Transfer occurs when in_valid & in_ready.
- On input transfer: `data[in_pos] <= in_data` and `out_valid[in_pos] <= 1`.
- Output transfer on slot i: occurs when out_valid[i] & out_ready[i]. Slot i goes EMPTY unless an input transfer targets slot i in the same cycle. In that case the slot stays FULL with the new word (flow-through refill).
- out_ready[i] while slot i is EMPTY has no effect.
- Slots are independent. Up to eight output transfers and one input transfer can occur in the same cycle.
- A FULL slot whose consumer is stalled blocks only inputs addressed to that slot. in_ready is evaluated against the current in_pos each cycle. There is no head-of-line state.
- Data registers load only on input transfer. Output transfers do not clear data; data is held after drain.
- Reset (rst_n low at a clk edge):
  - all out_valid clear to 8'h00;
  - data1…data8 clear to 32'h0;
  - accept_cnt clears to 16'h0.
  - Reset overrides any same-cycle transfer. Words in flight are discarded.
- in_ready is combinational from in_valid-independent state plus in_pos and out_ready. It is asserted during reset only as the formula dictates, but nothing is captured while rst_n=0.

## Timing
- Latency: a word accepted at edge N is visible on data[k]/out_valid[k] after edge N (one cycle).
- Throughput: one word per cycle aggregate. A single slot sustains one word per cycle when its consumer holds out_ready high.
- Combinational paths:
  - out_ready → in_ready;
  - in_pos → in_ready.
  - There is no path from in_data or in_valid to any output.
- Producer rule: in_pos and in_data must be held stable while in_valid=1 and in_ready=0. The block does not rely on this for correctness.
- The data/out_valid outputs are driven directly from registers.

## Configuration
- DEMUX3_STATS_EN defined:
  - accept_cnt port and a 16-bit counter are present.
  - The counter increments by 1 on each input transfer.
  - It saturates at 16'hFFFF and never wraps.
- DEMUX3_STATS_EN undefined: the accept_cnt port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with in_valid=1, in_pos=3, in_data=32'hDEADBEEF → after reset, out_valid=8'h00, data4=0, accept_cnt=0.
- Single delivery: in_pos=3'b101, in_data=32'h12345678, one cycle, out_ready=0 → out_valid=8'b0010_0000, data6=32'h12345678 held until out_ready[5]=1, then out_valid[5] clears next cycle.
- Backpressure: slot 2 FULL with out_ready[1]=0, present in_pos=1 → in_ready=0 and slot 2 is unchanged. Switch to in_pos=2 → in_ready=1, and slot 3 loads.
- Flow-through refill: slot 1 FULL with 32'hA, out_ready[0]=1, input in_pos=0 with 32'hB in the same cycle → in_ready=1, out_valid[0] stays 1, data1=32'hB next cycle.
- Streaming: 8 back-to-back words 32'h100+i to in_pos=i with all out_ready=1 → 8 accepts in 8 cycles, each out_valid bit pulses exactly once, accept_cnt=8 (stats build).
- Saturation (stats build): 65,540 accepts → accept_cnt stops at 16'hFFFF. Mid-stream reset → 0 on the next cycle.
